// File: rtl/traffic_request_conditioner.sv
// Pedestrian button conditioner and one-second time base for the traffic-light controller.
// Optional post-ack request hold-off is compiled in with `define REQ_HOLDOFF_EN.
module traffic_request_conditioner #(
    parameter int CLK_FREQ    = 1_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int HOLDOFF_S   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       req_ack,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       req_pending,
    output logic       sec_tick,
    output logic [7:0] press_cnt
);

    localparam int DB_CYCLES = CLK_FREQ * DEBOUNCE_MS / 1000;
    localparam int DB_W      = $clog2(DB_CYCLES + 1);
    localparam int TICK_W    = $clog2(CLK_FREQ);

`ifdef REQ_HOLDOFF_EN
    localparam int HO_W = $clog2(HOLDOFF_S + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        HOLDOFF = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1
    } state_t;
`endif

    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic              btn_level_q, btn_level_d;
    logic              btn_level_prev_q, btn_level_prev_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]        press_cnt_q, press_cnt_d;
    state_t            state_q, state_d;
`ifdef REQ_HOLDOFF_EN
    logic [HO_W-1:0]   ho_cnt_q, ho_cnt_d;
`endif

    // Synchroniser, debounce and edge detect
    always_comb begin
        s1_d             = btn_raw;
        s2_d             = s1_q;
        btn_level_prev_d = btn_level_q;
        btn_level_d      = btn_level_q;
        db_cnt_d         = '0;
        if (s2_q != btn_level_q) begin
            // The level flips one cycle after a full window of disagreement.
            if (db_cnt_q == DB_W'(DB_CYCLES)) begin
                btn_level_d = ~btn_level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        tick_cnt_d = tick_cnt_q + 1'b1;
        if (sec_tick) begin
            tick_cnt_d = '0;
        end
    end

    assign sec_tick    = (tick_cnt_q == TICK_W'(CLK_FREQ - 1));
    assign press_pulse = btn_level_q & ~btn_level_prev_q;
    assign btn_level   = btn_level_q;
    assign req_pending = (state_q == PENDING);
    assign press_cnt   = press_cnt_q;

    // Request FSM
    always_comb begin
        state_d     = state_q;
        press_cnt_d = press_cnt_q;
`ifdef REQ_HOLDOFF_EN
        ho_cnt_d    = ho_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (press_pulse) begin
                    state_d = PENDING;
                    if (press_cnt_q != 8'hFF) begin
                        press_cnt_d = press_cnt_q + 8'd1;
                    end
                end
            end
            PENDING: begin
                if (req_ack) begin
`ifdef REQ_HOLDOFF_EN
                    state_d  = HOLDOFF;
                    ho_cnt_d = '0;
`else
                    state_d  = IDLE;
`endif
                end
            end
`ifdef REQ_HOLDOFF_EN
            HOLDOFF: begin
                if (sec_tick) begin
                    if (ho_cnt_q == HO_W'(HOLDOFF_S - 1)) begin
                        state_d = IDLE;
                    end else begin
                        ho_cnt_d = ho_cnt_q + 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q             <= 1'b0;
            s2_q             <= 1'b0;
            btn_level_q      <= 1'b0;
            btn_level_prev_q <= 1'b0;
            db_cnt_q         <= '0;
            tick_cnt_q       <= '0;
            press_cnt_q      <= '0;
            state_q          <= IDLE;
        end else begin
            s1_q             <= s1_d;
            s2_q             <= s2_d;
            btn_level_q      <= btn_level_d;
            btn_level_prev_q <= btn_level_prev_d;
            db_cnt_q         <= db_cnt_d;
            tick_cnt_q       <= tick_cnt_d;
            press_cnt_q      <= press_cnt_d;
            state_q          <= state_d;
        end
    end

`ifdef REQ_HOLDOFF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ho_cnt_q <= '0;
        end else begin
            ho_cnt_q <= ho_cnt_d;
        end
    end
`endif

endmodule
